pipeline_ctrl: RTL and testbench

Hazard and sequencing controller for the 5-stage pipeline. It generates the enable and flush strobes for the PC and for the IF/ID, ID/EX, EX/MEM and MEM/WB registers (including the MEM-stage PC+4 register). It covers load-use stalls, taken-branch flushes resolved in MEM, data-memory wait states, and a halt/drain sequence. It also provides saturating performance counters and a memory-timeout flag.

---
 rtl/pipeline_ctrl_pkg.sv | 25 ++
 rtl/pipeline_ctrl_if.sv | 40 ++++
 rtl/pipeline_ctrl_sat_counter.sv | 22 ++
 rtl/pipeline_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard/sequencing controller.
package pipeline_ctrl_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  // A load in EX feeding a register the ID instruction reads; x0 never hazards.
  function automatic logic load_use_hazard(
    input logic [REG_IDX_W-1:0] rs1,
    input logic [REG_IDX_W-1:0] rs2,
    input logic                 uses_rs2,
    input logic [REG_IDX_W-1:0] rd,
    input logic                 memread,
    input logic                 regwrite
  );
    return memread && regwrite && (rd != {REG_IDX_W{1'b0}}) &&
           ((rd == rs1) || (uses_rs2 && (rd == rs2)));
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs from the pipeline and the strobes the controller returns.
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic [REG_IDX_W-1:0] id_rs1;
  logic [REG_IDX_W-1:0] id_rs2;
  logic                 id_uses_rs2;
  logic [REG_IDX_W-1:0] ex_rd;
  logic                 ex_memread;
  logic                 ex_regwrite;
  logic                 mem_branch_taken;
  logic                 dmem_req;
  logic                 dmem_ready;
  logic                 halt_req;

  logic pc_en;
  logic ifid_en;
  logic idex_en;
  logic exmem_en;
  logic memwb_en;
  logic ifid_flush;
  logic idex_flush;
  logic exmem_flush;
  logic pc_sel_branch;

  modport master (
    output id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_memread, ex_regwrite,
           mem_branch_taken, dmem_req, dmem_ready, halt_req,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, pc_sel_branch
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_memread, ex_regwrite,
           mem_branch_taken, dmem_req, dmem_ready, halt_req,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, pc_sel_branch
  );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter clocked on the falling edge like the pipeline registers.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, holding at all ones instead of wrapping.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      count <= {W{1'b0}};
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller: stalls, branch flushes, memory waits,
// halt/drain sequencing, performance counters and memory-timeout flag.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  pipeline_ctrl_if.slave   bus,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  state_t              state_r;
  state_t              state_s;
  logic [WAIT_W-1:0]   wait_cnt_r;
  logic [DRAIN_W-1:0]  drain_cnt_r;
  logic                halted_r;
  logic                timeout_r;

  logic mem_wait_s;
  logic load_use_s;
  logic stall_inc_s;
  logic flush_inc_s;
  logic pc_en_s, ifid_en_s, idex_en_s, exmem_en_s, memwb_en_s;
  logic ifid_flush_s, idex_flush_s, exmem_flush_s, pc_sel_branch_s;

  assign mem_wait_s = bus.dmem_req && !bus.dmem_ready;
  assign load_use_s = load_use_hazard(bus.id_rs1, bus.id_rs2, bus.id_uses_rs2,
                                      bus.ex_rd, bus.ex_memread, bus.ex_regwrite);

  // Strobes, counter increments and next state from the current state and hazards.
  always_comb begin
    state_s         = state_r;
    stall_inc_s     = 1'b0;
    flush_inc_s     = 1'b0;
    pc_en_s         = 1'b0;
    ifid_en_s       = 1'b0;
    idex_en_s       = 1'b0;
    exmem_en_s      = 1'b0;
    memwb_en_s      = 1'b0;
    ifid_flush_s    = 1'b0;
    idex_flush_s    = 1'b0;
    exmem_flush_s   = 1'b0;
    pc_sel_branch_s = 1'b0;
    if (!reset) begin
      // Load bubbles everywhere while reset is held.
      {pc_en_s, ifid_en_s, idex_en_s, exmem_en_s, memwb_en_s} = 5'b11111;
      {ifid_flush_s, idex_flush_s, exmem_flush_s}              = 3'b111;
      state_s = RUN;
    end else begin
      case (state_r)
        RUN: begin
          if (mem_wait_s) begin
            stall_inc_s = 1'b1;
          end else if (bus.mem_branch_taken) begin
            {pc_en_s, ifid_en_s, idex_en_s, exmem_en_s, memwb_en_s} = 5'b11111;
            {ifid_flush_s, idex_flush_s, exmem_flush_s}              = 3'b111;
            pc_sel_branch_s = 1'b1;
            flush_inc_s     = 1'b1;
          end else if (load_use_s) begin
            {idex_en_s, exmem_en_s, memwb_en_s} = 3'b111;
            idex_flush_s = 1'b1;
            stall_inc_s  = 1'b1;
          end else begin
            {pc_en_s, ifid_en_s, idex_en_s, exmem_en_s, memwb_en_s} = 5'b11111;
          end
          // A pending branch (even one frozen by a wait) must flush before draining.
          if (bus.halt_req && !bus.mem_branch_taken) begin
            state_s = DRAIN;
          end else begin
            state_s = RUN;
          end
        end
        DRAIN: begin
          if (mem_wait_s) begin
            stall_inc_s = 1'b1;
          end else begin
            {idex_en_s, exmem_en_s, memwb_en_s} = 3'b111;
            idex_flush_s = 1'b1;
          end
          if (!bus.halt_req) begin
            state_s = RUN;
          end else if (!mem_wait_s && (drain_cnt_r == DRAIN_LAST)) begin
            state_s = HALTED;
          end else begin
            state_s = DRAIN;
          end
        end
        HALTED: begin
          if (!bus.halt_req) begin
            state_s = RUN;
          end else begin
            state_s = HALTED;
          end
        end
        default: begin
          state_s = RUN;
        end
      endcase
    end
  end

  // State register, drain progress and halted flag.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= RUN;
      drain_cnt_r <= {DRAIN_W{1'b0}};
      halted_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      halted_r <= (state_s == HALTED);
      if ((state_r == DRAIN) && (state_s == DRAIN)) begin
        drain_cnt_r <= mem_wait_s ? drain_cnt_r : drain_cnt_r + DRAIN_W'(1);
      end else begin
        drain_cnt_r <= {DRAIN_W{1'b0}};
      end
    end
  end

  // Consecutive wait-state counter and sticky timeout flag.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_r <= {WAIT_W{1'b0}};
      timeout_r  <= 1'b0;
    end else if (mem_wait_s) begin
      wait_cnt_r <= (wait_cnt_r == WAIT_MAX) ? wait_cnt_r : wait_cnt_r + WAIT_W'(1);
      timeout_r  <= timeout_r || (wait_cnt_r >= (WAIT_MAX - WAIT_W'(1)));
    end else begin
      wait_cnt_r <= {WAIT_W{1'b0}};
      timeout_r  <= timeout_r;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc_s),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc_s),
    .count (flush_count)
  );

  assign bus.pc_en         = pc_en_s;
  assign bus.ifid_en       = ifid_en_s;
  assign bus.idex_en       = idex_en_s;
  assign bus.exmem_en      = exmem_en_s;
  assign bus.memwb_en      = memwb_en_s;
  assign bus.ifid_flush    = ifid_flush_s;
  assign bus.idex_flush    = idex_flush_s;
  assign bus.exmem_flush   = exmem_flush_s;
  assign bus.pc_sel_branch = pc_sel_branch_s;
  assign halted            = halted_r;
  assign mem_timeout       = timeout_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: per-cycle expected strobes and counters.
module tb_pipeline_ctrl;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = 3;

  // Strobe order: pc, ifid, idex, exmem, memwb, ifid_f, idex_f, exmem_f, sel
  localparam logic [8:0] S_RST  = 9'b11111_111_0;
  localparam logic [8:0] S_RUN  = 9'b11111_000_0;
  localparam logic [8:0] S_WAIT = 9'b00000_000_0;
  localparam logic [8:0] S_BR   = 9'b11111_111_1;
  localparam logic [8:0] S_LU   = 9'b00111_010_0;
  localparam logic [8:0] S_DRN  = 9'b00111_010_0;
  localparam logic [8:0] S_HLT  = 9'b00000_000_0;

  logic             clk = 1'b0;
  logic             reset;
  logic             halted;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  pipeline_ctrl_if bus_if();

  pipeline_ctrl #(
    .DRAIN_CYCLES (4),
    .MEM_TIMEOUT  (4),
    .CNT_W        (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_if),
    .halted      (halted),
    .mem_timeout (mem_timeout),
    .stall_count (stall_count),
    .flush_count (flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] strobes;
    logic       halted;
    logic       timeout;
    int         stall;
    int         flush;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [8:0] strobes_now();
    return {bus_if.pc_en, bus_if.ifid_en, bus_if.idex_en, bus_if.exmem_en, bus_if.memwb_en,
            bus_if.ifid_flush, bus_if.idex_flush, bus_if.exmem_flush, bus_if.pc_sel_branch};
  endfunction

  // Inputs are set just after a falling edge; sample mid-cycle, then advance one edge.
  task automatic step(input string tag, input logic [8:0] s, input logic h, input logic t,
                      input bit st, input bit fl);
    exp_t e;
    e.strobes = s;
    e.halted  = h;
    e.timeout = t;
    e.stall   = exp_stall;
    e.flush   = exp_flush;
    sb_q.push_back(e);
    if (st && exp_stall < CNT_MAX) exp_stall++;
    if (fl && exp_flush < CNT_MAX) exp_flush++;
    #2;
    e = sb_q.pop_front();
    chk({tag, ".strobes"}, 32'(strobes_now()), 32'(e.strobes));
    chk({tag, ".halted"},  32'(halted),        32'(e.halted));
    chk({tag, ".timeout"}, 32'(mem_timeout),   32'(e.timeout));
    chk({tag, ".stall"},   32'(stall_count),   32'(e.stall));
    chk({tag, ".flush"},   32'(flush_count),   32'(e.flush));
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus_if.id_rs1           = 5'd0;
    bus_if.id_rs2           = 5'd0;
    bus_if.id_uses_rs2      = 1'b0;
    bus_if.ex_rd            = 5'd0;
    bus_if.ex_memread       = 1'b0;
    bus_if.ex_regwrite      = 1'b0;
    bus_if.mem_branch_taken = 1'b0;
    bus_if.dmem_req         = 1'b0;
    bus_if.dmem_ready       = 1'b0;
    bus_if.halt_req         = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset     = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
    step("rst", S_RST, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic uses2, input logic regwr);
    bus_if.ex_memread  = 1'b1;
    bus_if.ex_regwrite = regwr;
    bus_if.ex_rd       = rd;
    bus_if.id_rs1      = rs1;
    bus_if.id_rs2      = rs2;
    bus_if.id_uses_rs2 = uses2;
  endtask

  initial begin
    do_reset();
    step("idle", S_RUN, 1'b0, 1'b0, 1'b0, 1'b0);

    // Load-use on rs1, then the bubble moves on; x0, rs2 and non-writing loads.
    set_load(5'd5, 5'd5, 5'd0, 1'b0, 1'b1);
    step("lu_rs1", S_LU, 1'b0, 1'b0, 1'b1, 1'b0);
    clear_inputs();
    step("lu_after", S_RUN, 1'b0, 1'b0, 1'b0, 1'b0);
    set_load(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    step("lu_x0", S_RUN, 1'b0, 1'b0, 1'b0, 1'b0);
    set_load(5'd7, 5'd3, 5'd7, 1'b1, 1'b1);
    step("lu_rs2", S_LU, 1'b0, 1'b0, 1'b1, 1'b0);
    set_load(5'd7, 5'd3, 5'd7, 1'b0, 1'b1);
    step("lu_rs2_unused", S_RUN, 1'b0, 1'b0, 1'b0, 1'b0);
    set_load(5'd3, 5'd3, 5'd0, 1'b0, 1'b0);
    step("lu_no_regwr", S_RUN, 1'b0, 1'b0, 1'b0, 1'b0);
    clear_inputs();
    step("lu_end", S_RUN, 1'b0, 1'b0, 1'b0, 1'b0);

    // Single-cycle branch, then a branch held behind three wait states.
    do_reset();
    bus_if.mem_branch_taken = 1'b1;
    step("br", S_BR, 1'b0, 1'b0, 1'b0, 1'b1);
    bus_if.mem_branch_taken = 1'b0;
    step("br_after", S_RUN, 1'b0, 1'b0, 1'b0, 1'b0);
    bus_if.mem_branch_taken = 1'b1;
    bus_if.dmem_req         = 1'b1;
    for (int k = 0; k < 3; k++) step("br_wait", S_WAIT, 1'b0, 1'b0, 1'b1, 1'b0);
    bus_if.dmem_ready = 1'b1;
    step("br_ready", S_BR, 1'b0, 1'b0, 1'b0, 1'b1);
    clear_inputs();
    step("br_end", S_RUN, 1'b0, 1'b0, 1'b0, 1'b0);

    // Six waits: timeout after the fourth, sticky after ready; stall count saturates.
    do_reset();
    bus_if.dmem_req = 1'b1;
    for (int k = 1; k <= 6; k++) step("tmo_wait", S_WAIT, 1'b0, logic'(k >= 5), 1'b1, 1'b0);
    bus_if.dmem_ready = 1'b1;
    step("tmo_ready", S_RUN, 1'b0, 1'b1, 1'b0, 1'b0);
    clear_inputs();
    step("tmo_sticky", S_RUN, 1'b0, 1'b1, 1'b0, 1'b0);

    // Wait counter clears between non-consecutive waits.
    do_reset();
    bus_if.dmem_req = 1'b1;
    for (int k = 0; k < 3; k++) step("wclr_a", S_WAIT, 1'b0, 1'b0, 1'b1, 1'b0);
    bus_if.dmem_ready = 1'b1;
    step("wclr_gap", S_RUN, 1'b0, 1'b0, 1'b0, 1'b0);
    bus_if.dmem_ready = 1'b0;
    for (int k = 0; k < 3; k++) step("wclr_b", S_WAIT, 1'b0, 1'b0, 1'b1, 1'b0);
    clear_inputs();
    step("wclr_end", S_RUN, 1'b0, 1'b0, 1'b0, 1'b0);

    // Stall counter saturation with five load-use stalls.
    do_reset();
    set_load(5'd9, 5'd9, 5'd0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) step("sat_lu", S_LU, 1'b0, 1'b0, 1'b1, 1'b0);
    clear_inputs();
    step("sat_end", S_RUN, 1'b0, 1'b0, 1'b0, 1'b0);

    // Full halt: four drain cycles, halted, ignored branch, resume.
    do_reset();
    bus_if.halt_req = 1'b1;
    step("halt_run", S_RUN, 1'b0, 1'b0, 1'b0, 1'b0);
    set_load(5'd4, 5'd4, 5'd0, 1'b0, 1'b1);
    step("drain1_lu", S_DRN, 1'b0, 1'b0, 1'b0, 1'b0);
    bus_if.ex_memread = 1'b0;
    for (int k = 2; k <= 4; k++) step("drain", S_DRN, 1'b0, 1'b0, 1'b0, 1'b0);
    step("halted", S_HLT, 1'b1, 1'b0, 1'b0, 1'b0);
    bus_if.mem_branch_taken = 1'b1;
    step("halted_br", S_HLT, 1'b1, 1'b0, 1'b0, 1'b0);
    clear_inputs();
    step("halted_rel", S_HLT, 1'b1, 1'b0, 1'b0, 1'b0);
    step("resumed", S_RUN, 1'b0, 1'b0, 1'b0, 1'b0);

    // Halt dropped in the second drain cycle.
    bus_if.halt_req = 1'b1;
    step("abort_run", S_RUN, 1'b0, 1'b0, 1'b0, 1'b0);
    step("abort_d1", S_DRN, 1'b0, 1'b0, 1'b0, 1'b0);
    bus_if.halt_req = 1'b0;
    step("abort_d2", S_DRN, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step("abort_run2", S_RUN, 1'b0, 1'b0, 1'b0, 1'b0);

    // Halt requested alongside a branch waits one cycle; a wait freezes the drain.
    do_reset();
    bus_if.halt_req         = 1'b1;
    bus_if.mem_branch_taken = 1'b1;
    step("hbr_br", S_BR, 1'b0, 1'b0, 1'b0, 1'b1);
    bus_if.mem_branch_taken = 1'b0;
    step("hbr_run", S_RUN, 1'b0, 1'b0, 1'b0, 1'b0);
    step("hbr_d1", S_DRN, 1'b0, 1'b0, 1'b0, 1'b0);
    bus_if.dmem_req = 1'b1;
    for (int k = 0; k < 2; k++) step("hbr_dwait", S_WAIT, 1'b0, 1'b0, 1'b1, 1'b0);
    bus_if.dmem_req = 1'b0;
    for (int k = 2; k <= 4; k++) step("hbr_d", S_DRN, 1'b0, 1'b0, 1'b0, 1'b0);
    step("hbr_halted", S_HLT, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a drain with non-zero counters.
    do_reset();
    set_load(5'd2, 5'd2, 5'd0, 1'b0, 1'b1);
    step("mid_lu", S_LU, 1'b0, 1'b0, 1'b1, 1'b0);
    clear_inputs();
    bus_if.halt_req = 1'b1;
    step("mid_run", S_RUN, 1'b0, 1'b0, 1'b0, 1'b0);
    step("mid_d1", S_DRN, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    step("mid_after", S_RUN, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
